// File: rtl/ssd1331_pkg.sv
// ssd1331_pkg: shared types and constants for the SSD1331 power-up sequencer.
//   state_e   sequencer states
//   CMD_*     SSD1331 command opcodes used by the init stream
//   packet_t  one SPI packet {byte count, D/C mask, bytes}; byte 0 sits in data[7:0]
package ssd1331_pkg;

  localparam int PKT_BYTES = 8;
  localparam int INIT_LEN  = 5;
  localparam int IDX_W     = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWR,
    ST_RES_LO,
    ST_RES_HI,
    ST_SEND,
    ST_DRAIN,
    ST_VCC,
    ST_DISP,
    ST_DRAIN2,
    ST_CLEAR,
    ST_DRAIN3,
    ST_DONE
  } state_e;

  localparam logic [7:0] CMD_UNLOCK      = 8'hFD;
  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_REMAP       = 8'hA0;
  localparam logic [7:0] CMD_START_LINE  = 8'hA1;
  localparam logic [7:0] CMD_OFFSET      = 8'hA2;
  localparam logic [7:0] CMD_NORMAL      = 8'hA4;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_MASTER_CFG  = 8'hAD;
  localparam logic [7:0] CMD_PWR_SAVE    = 8'hB0;
  localparam logic [7:0] CMD_PHASE_LEN   = 8'hB1;
  localparam logic [7:0] CMD_CLK_DIV     = 8'hB3;
  localparam logic [7:0] CMD_PRECHG_A    = 8'h8A;
  localparam logic [7:0] CMD_PRECHG_B    = 8'h8B;
  localparam logic [7:0] CMD_PRECHG_C    = 8'h8C;
  localparam logic [7:0] CMD_PRECHG_LVL  = 8'hBB;
  localparam logic [7:0] CMD_VCOMH       = 8'hBE;
  localparam logic [7:0] CMD_MASTER_CUR  = 8'h87;
  localparam logic [7:0] CMD_CONTRAST_A  = 8'h81;
  localparam logic [7:0] CMD_CLEAR       = 8'h25;

  typedef struct packed {
    logic [4:0]             n;
    logic [PKT_BYTES-1:0]   dc;
    logic [8*PKT_BYTES-1:0] data;
  } packet_t;

  localparam packet_t PKT_DISP_ON = '{n: 5'd1, dc: '0, data: {56'h0, CMD_DISP_ON}};

  // Clear the full 96x64 window: columns 0..0x5F, rows 0..0x3F.
  localparam packet_t PKT_CLEAR = '{n: 5'd5, dc: '0,
                                    data: {24'h0, 8'h3F, 8'h5F, 8'h00, 8'h00, CMD_CLEAR}};

endpackage

// File: rtl/ssd1331_init_rom.sv
// ssd1331_init_rom: combinational INIT command ROM (INIT_LEN packets, all command bytes).
//   i_idx  packet index
//   o_pkt  packet at that index; zero for indices past the end
module ssd1331_init_rom
  import ssd1331_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output packet_t          o_pkt
);

  always_comb begin
    o_pkt = '0;
    case (i_idx)
      3'd0: begin
        o_pkt.n    = 5'd3;
        o_pkt.data = {40'h0, CMD_DISP_OFF, 8'h12, CMD_UNLOCK};
      end
      3'd1: begin
        o_pkt.n    = 5'd7;
        o_pkt.data = {8'h00, CMD_NORMAL, 8'h00, CMD_OFFSET, 8'h00, CMD_START_LINE,
                      8'h72, CMD_REMAP};
      end
      3'd2: begin
        o_pkt.n    = 5'd8;
        o_pkt.data = {8'h31, CMD_PHASE_LEN, 8'h0B, CMD_PWR_SAVE, 8'h8E, CMD_MASTER_CFG,
                      8'h3F, CMD_MUX_RATIO};
      end
      3'd3: begin
        o_pkt.n    = 5'd8;
        o_pkt.data = {8'h64, CMD_PRECHG_C, 8'h78, CMD_PRECHG_B, 8'h64, CMD_PRECHG_A,
                      8'hF0, CMD_CLK_DIV};
      end
      3'd4: begin
        o_pkt.n    = 5'd8;
        o_pkt.data = {8'h91, CMD_CONTRAST_A, 8'h06, CMD_MASTER_CUR, 8'h3E, CMD_VCOMH,
                      8'h3A, CMD_PRECHG_LVL};
      end
      default: o_pkt = '0;
    endcase
  end

endmodule

// File: rtl/ssd1331_init_sequencer.sv
// ssd1331_init_sequencer: SSD1331 power-up sequencer feeding an N-byte MOSI SPI buffer.
//   i_SCK, i_RST        clock, async active-high reset
//   i_EN                starts the sequence from IDLE
//   i_MOSI_FINAL_BYTE   rising edge = current packet accepted by the buffer
//   i_CS                buffer chip select; high = SPI line idle
//   o_DATA/o_DC/o_N_transmit/o_START  packet presented to the buffer
//   o_PMODEN/o_RES/o_VCCEN            panel power/reset pins (o_RES active low)
//   o_READY             initialisation complete
// Optional: define SSD1331_CLEAR_EN to send a clear-window packet after display-on.
module ssd1331_init_sequencer
  import ssd1331_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N       = 8,
  parameter int PWR_DLY = 100000,
  parameter int RES_DLY = 15,
  parameter int VCC_DLY = 125000
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic               i_EN,
  input  logic               i_MOSI_FINAL_BYTE,
  input  logic               i_CS,
  output logic [WIDTH*N-1:0] o_DATA,
  output logic [N-1:0]       o_DC,
  output logic [4:0]         o_N_transmit,
  output logic               o_START,
  output logic               o_PMODEN,
  output logic               o_RES,
  output logic               o_VCCEN,
  output logic               o_READY
);

  localparam int MAX_DLY = (PWR_DLY > RES_DLY) ?
                           ((PWR_DLY > VCC_DLY) ? PWR_DLY : VCC_DLY) :
                           ((RES_DLY > VCC_DLY) ? RES_DLY : VCC_DLY);
  localparam int CNT_W   = $clog2(MAX_DLY) + 1;
  localparam int NB      = (N < PKT_BYTES) ? N : PKT_BYTES;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fin_q;
  logic               start_q, start_d;
  logic               pmoden_q, pmoden_d;
  logic               res_q, res_d;
  logic               vccen_q, vccen_d;
  logic               ready_q, ready_d;
  logic [WIDTH*N-1:0] data_q, data_d;
  logic [N-1:0]       dc_q, dc_d;
  logic [4:0]         ntx_q, ntx_d;
  logic               accept;
  packet_t            rom_pkt;
  packet_t            pkt_sel;

  // A delay of 0 or 1 both leave after a single cycle.
  function automatic logic dly_done(input logic [CNT_W-1:0] cnt, input int dly);
    return (int'(cnt) + 1) >= dly;
  endfunction

  ssd1331_init_rom u_rom (
    .i_idx (idx_d),
    .o_pkt (rom_pkt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    accept  = i_MOSI_FINAL_BYTE & ~fin_q;
    case (state_q)
      ST_IDLE:   if (i_EN) state_d = ST_PWR;
      ST_PWR: begin
        if (dly_done(cnt_q, PWR_DLY)) state_d = ST_RES_LO;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      ST_RES_LO: begin
        if (dly_done(cnt_q, RES_DLY)) state_d = ST_RES_HI;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      ST_RES_HI: begin
        if (dly_done(cnt_q, RES_DLY)) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (idx_q == IDX_W'(INIT_LEN - 1)) state_d = ST_DRAIN;
          else                               idx_d   = idx_q + 1'b1;
        end
      end
      ST_DRAIN:  if (i_CS) state_d = ST_VCC;
      ST_VCC: begin
        if (dly_done(cnt_q, VCC_DLY)) state_d = ST_DISP;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      ST_DISP:   if (accept) state_d = ST_DRAIN2;
      ST_DRAIN2: begin
`ifdef SSD1331_CLEAR_EN
        if (i_CS) state_d = ST_CLEAR;
`else
        if (i_CS) state_d = ST_DONE;
`endif
      end
      ST_CLEAR:  if (accept) state_d = ST_DRAIN3;
      ST_DRAIN3: if (i_CS) state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    start_d  = (state_d == ST_SEND) || (state_d == ST_DISP) || (state_d == ST_CLEAR);
    pmoden_d = (state_d != ST_IDLE);
    res_d    = (state_d != ST_RES_LO);
    vccen_d  = (state_d == ST_VCC)    || (state_d == ST_DISP)   || (state_d == ST_DRAIN2) ||
               (state_d == ST_CLEAR)  || (state_d == ST_DRAIN3) || (state_d == ST_DONE);
    ready_d  = (state_d == ST_DONE);

    case (state_d)
      ST_DISP:  pkt_sel = PKT_DISP_ON;
      ST_CLEAR: pkt_sel = PKT_CLEAR;
      default:  pkt_sel = rom_pkt;
    endcase

    // Packet fields only change while a request is up; otherwise they hold.
    data_d = data_q;
    dc_d   = dc_q;
    ntx_d  = ntx_q;
    if (start_d) begin
      data_d = '0;
      dc_d   = '0;
      ntx_d  = pkt_sel.n;
      for (int unsigned k = 0; k < NB; k++) begin
        if (k < pkt_sel.n) begin
          data_d[WIDTH*k +: WIDTH] = WIDTH'(pkt_sel.data[8*k +: 8]);
          dc_d[k]                  = pkt_sel.dc[k];
        end
      end
    end
  end

  always_ff @(posedge i_SCK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      start_q  <= 1'b0;
      pmoden_q <= 1'b0;
      res_q    <= 1'b1;
      vccen_q  <= 1'b0;
      ready_q  <= 1'b0;
      data_q   <= '0;
      dc_q     <= '0;
      ntx_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      fin_q    <= i_MOSI_FINAL_BYTE;
      start_q  <= start_d;
      pmoden_q <= pmoden_d;
      res_q    <= res_d;
      vccen_q  <= vccen_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      dc_q     <= dc_d;
      ntx_q    <= ntx_d;
    end
  end

  assign o_DATA       = data_q;
  assign o_DC         = dc_q;
  assign o_N_transmit = ntx_q;
  assign o_START      = start_q;
  assign o_PMODEN     = pmoden_q;
  assign o_RES        = res_q;
  assign o_VCCEN      = vccen_q;
  assign o_READY      = ready_q;

endmodule

// File: doc/ssd1331_init_sequencer.md
Name: ssd1331_init_sequencer

Overview:
- Upstream feeder for the N-byte MOSI SPI buffer. Runs the SSD1331 panel power-up sequence and drives the PMODEN, RES and VCCEN pins.
- Walks a constant ROM of command packets and presents each one as {data, DC mask, byte count, start} to the buffer.
- Advances one packet per accept, where an accept is a rising edge on the buffer's final-byte flag.
- Raises o_READY when the panel is on and the SPI path is free for pixel traffic.

Parameters:
- WIDTH, 8, bits per byte.
- N, 8, maximum bytes per packet. Matches the buffer.
- PWR_DLY, 100000, i_SCK cycles from PMODEN high to RES low.
- RES_DLY, 15, i_SCK cycles RES is held low, and again after RES returns high.
- VCC_DLY, 125000, i_SCK cycles after VCCEN high before the display-on packet.
- Delay counter width is $clog2 of the largest delay plus 1.

Ports:
- i_SCK  in  1  clock; same clock as the SPI buffer.
- i_RST  in  1  asynchronous, active-high reset.
- i_EN  in  1  level; starts the sequence from IDLE.
- i_MOSI_FINAL_BYTE  in  1  from buffer; a rising edge means the current packet is accepted.
- i_CS  in  1  from buffer o_CS; high means the SPI line is idle.
- o_DATA  out  WIDTH*N  packet bytes; byte k is in [WIDTH*k +: WIDTH]; byte 0 is sent first.
- o_DC  out  N  bit k is the D/C value for byte k.
- o_N_transmit  out  5  number of valid bytes, 1..N.
- o_START  out  1  request to the buffer.
- o_PMODEN  out  1  panel logic power enable.
- o_RES  out  1  panel reset, active low.
- o_VCCEN  out  1  panel VCC enable.
- o_READY  out  1  initialisation complete.

Behaviour:
- Reset values, applied asynchronously and immediately, including mid-operation:
  - o_START, o_PMODEN, o_VCCEN, o_READY, o_DATA, o_DC, o_N_transmit = 0.
  - o_RES = 1.
  - State = IDLE, packet index = 0.
- States, with delays counted on i_SCK:
  - IDLE: go to PWR when i_EN = 1.
  - PWR: o_PMODEN = 1; wait PWR_DLY.
  - RES_LO: o_RES = 0; wait RES_DLY.
  - RES_HI: o_RES = 1; wait RES_DLY.
  - SEND: stream the INIT ROM packets (see the SEND rules below).
  - DRAIN: wait for i_CS = 1.
  - VCC: o_VCCEN = 1; wait VCC_DLY.
  - DISP: send the single packet 0xAF, N=1, DC=0, using the SEND handshake.
  - DRAIN2: wait for i_CS = 1.
  - DONE: o_READY = 1; hold until reset. i_EN is ignored in DONE.
- SEND rules:
  - o_START = 1; outputs show ROM[index].
  - Accept = i_MOSI_FINAL_BYTE high this cycle and low the previous cycle. The previous value is a register, cleared by reset.
  - On accept with index < last: the next ROM entry appears on the outputs the following cycle, and o_START stays high. This leaves WIDTH-1 cycles of margin before the buffer reloads.
  - On accept of the last entry: o_START drops the next cycle; go to DRAIN.
  - i_MOSI_FINAL_BYTE held high for several cycles counts as one accept.
  - Outputs are stable between accepts.
- Unused bytes and DC bits above o_N_transmit are driven to 0.
- A delay of 0 means leave the state after one cycle.
- i_EN dropping mid-sequence has no effect; only reset aborts the sequence.
- All outputs are registered.

Optional Feature:
- Macro: SSD1331_CLEAR_EN.
- When defined: after DRAIN2, send the clear-window packet 0x25 0x00 0x00 0x5F 0x3F (N=5, DC=0), wait for i_CS = 1, then go to DONE.
- When not defined: DRAIN2 goes directly to DONE, and no extra packet is sent.

Decomposition:
- Package ssd1331_pkg holds:
  - state enum;
  - command opcodes (UNLOCK 0xFD, DISP_OFF 0xAE, DISP_ON 0xAF, CLEAR 0x25, ...);
  - INIT_LEN;
  - packet record type {n, dc, data}.
- The INIT ROM lives in one sub-module, ssd1331_init_rom: combinational index -> packet. INIT_LEN is 5. All DC bits are 0.
  - ROM0 = FD 12 AE (n=3)
  - ROM1 = A0 72 A1 00 A2 00 A4 (n=7)
  - ROM2 = A8 3F AD 8E B0 0B B1 31 (n=8)
  - ROM3 = B3 F0 8A 64 8B 78 8C 64 (n=8)
  - ROM4 = BB 3A BE 3E 87 06 81 91 (n=8)

Test Plan:
- Reset held, then released with i_EN=0 for 50 cycles -> all outputs stay at reset values and o_RES=1.
- Delays overridden to 4/2/4, i_EN=1, buffer model accepting after 8*n cycles:
  - o_PMODEN rises, o_RES is low for exactly 2 cycles.
  - First packet has o_DATA[23:0]=0xAE12FD, n=3, DC=0.
  - Exactly 5 ROM packets, then 0xAF, then o_READY=1.
- i_MOSI_FINAL_BYTE held high 5 cycles on packet 1 -> index advances once; packet 2 is not skipped.
- Reset asserted mid-SEND at packet 2 -> same-cycle o_START=0, o_PMODEN=0. After release with i_EN=1, the sequence restarts from PWR with packet 0.
- i_CS held low after the last ROM accept -> o_VCCEN stays 0 until i_CS=1.
- SSD1331_CLEAR_EN defined -> packet 0x3F5F000025 (n=5) follows 0xAF; o_READY rises only after it drains.
